// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared constants and set-2 to HID translation for the PS/2 keycode receiver
// Contents: frame FSM state encodings, PS/2 prefix bytes (E0 extended, F0 break),
// HID usage constants for the supported keys, and ps2_to_hid() translation.
package ps2_pkg;

  // Frame FSM states (plain constants so older tools and dumps read them as vectors)
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DATA   = 2'd1;
  localparam logic [1:0] ST_PARITY = 2'd2;
  localparam logic [1:0] ST_STOP   = 2'd3;

  // Scan code set 2 prefix bytes
  localparam logic [7:0] PS2_EXT = 8'hE0;
  localparam logic [7:0] PS2_BRK = 8'hF0;

  // HID usages produced by the translator
  localparam logic [7:0] HID_NONE  = 8'h00;
  localparam logic [7:0] HID_A     = 8'h04;
  localparam logic [7:0] HID_D     = 8'h07;
  localparam logic [7:0] HID_S     = 8'h16;
  localparam logic [7:0] HID_W     = 8'h1A;
  localparam logic [7:0] HID_ENTER = 8'h28;
  localparam logic [7:0] HID_ESC   = 8'h29;
  localparam logic [7:0] HID_SPACE = 8'h2C;
  localparam logic [7:0] HID_DOWN  = 8'h51;
  localparam logic [7:0] HID_UP    = 8'h52;

  // Unsupported codes map to HID_NONE, which the receiver treats as "ignore".
  function automatic logic [7:0] ps2_to_hid(input logic [7:0] code, input logic ext);
    logic [7:0] hid;
    hid = HID_NONE;
    if (ext) begin
      case (code)
        8'h75:   hid = HID_UP;
        8'h72:   hid = HID_DOWN;
        default: hid = HID_NONE;
      endcase
    end else begin
      case (code)
        8'h29:   hid = HID_SPACE;
        8'h1D:   hid = HID_W;
        8'h1C:   hid = HID_A;
        8'h1B:   hid = HID_S;
        8'h23:   hid = HID_D;
        8'h5A:   hid = HID_ENTER;
        8'h76:   hid = HID_ESC;
        default: hid = HID_NONE;
      endcase
    end
    return hid;
  endfunction

endpackage

// File: rtl/ps2_keycode_rx_if.sv
// rtl/ps2_keycode_rx_if.sv - PS/2 line and keycode output bundle for ps2_keycode_rx
// Signals: ps2_clk/ps2_data raw PS/2 lines; keycode current HID usage (00 = none);
// key_valid one-cycle pulse on keycode change; rx_error one-cycle pulse on frame error.
// Modports: master drives the PS/2 lines and observes outputs; slave is the receiver.
interface ps2_keycode_rx_if;
  logic       ps2_clk;
  logic       ps2_data;
  logic [7:0] keycode;
  logic       key_valid;
  logic       rx_error;

  modport master (
    output ps2_clk,
    output ps2_data,
    input  keycode,
    input  key_valid,
    input  rx_error
  );

  modport slave (
    input  ps2_clk,
    input  ps2_data,
    output keycode,
    output key_valid,
    output rx_error
  );
endinterface

// File: rtl/ps2_line_filter.sv
// rtl/ps2_line_filter.sv - PS/2 line synchronizers, ps2_clk glitch filter and falling-edge strobe
// Ports: Clk system clock; Reset synchronous active-high; i_ps2_clk/i_ps2_data raw lines;
// o_data synchronized data line; o_fall_strobe one-Clk pulse per filtered ps2_clk 1->0.
// Parameter FILTER_LEN: consecutive equal samples needed before the filtered clock moves.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic Clk,
  input  logic Reset,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output logic o_data,
  output logic o_fall_strobe
);

  localparam int CW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);

  logic [1:0]    r_clk_sync;
  logic [1:0]    r_data_sync;
  logic          r_clk_filt;
  logic [CW-1:0] r_cnt;
  logic          r_strobe;

  logic w_differs;
  logic w_flip;

  // r_cnt holds how many consecutive samples so far disagreed with the filtered level;
  // the FILTER_LEN-th disagreeing sample flips the filtered level.
  assign w_differs = r_clk_sync[1] != r_clk_filt;
  assign w_flip    = w_differs && (r_cnt == CW'(FILTER_LEN - 1));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
      r_clk_filt  <= 1'b1;
      r_cnt       <= '0;
      r_strobe    <= 1'b0;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
      r_data_sync <= {r_data_sync[0], i_ps2_data};
      r_strobe    <= w_flip && r_clk_filt;
      if (!w_differs) begin
        r_cnt <= '0;
      end else if (w_flip) begin
        r_clk_filt <= ~r_clk_filt;
        r_cnt      <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_data        = r_data_sync[1];
  assign o_fall_strobe = r_strobe;

endmodule

// File: rtl/ps2_keycode_rx.sv
// rtl/ps2_keycode_rx.sv - PS/2 keyboard frame receiver with set-2 to HID held-key tracking
// Ports: Clk 50 MHz system clock; Reset synchronous active-high;
// bus (ps2_keycode_rx_if.slave): ps2_clk/ps2_data in, keycode/key_valid/rx_error out.
// Parameters: FILTER_LEN ps2_clk glitch filter length; TIMEOUT_CYCLES idle limit inside a frame.
// Macro PS2_PARITY_CHECK_EN: when defined, odd-parity mismatches discard the byte with rx_error.
module ps2_keycode_rx
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic             Clk,
  input logic             Reset,
  ps2_keycode_rx_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic          w_data;
  logic          w_strobe;
  logic          w_parity_bad;
  logic          w_timeout_hit;
  logic [7:0]    w_hid;

  logic [1:0]    r_state;
  logic [2:0]    r_bit_cnt;
  logic [7:0]    r_shift;
  logic [7:0]    r_byte;
  logic          r_byte_rdy;
  logic [TW-1:0] r_timeout;
  logic          r_ext;
  logic          r_brk;
  logic [7:0]    r_keycode;
  logic          r_key_valid;
  logic          r_rx_error;

  ps2_line_filter #(
    .FILTER_LEN(FILTER_LEN)
  ) u_line_filter (
    .Clk          (Clk),
    .Reset        (Reset),
    .i_ps2_clk    (bus.ps2_clk),
    .i_ps2_data   (bus.ps2_data),
    .o_data       (w_data),
    .o_fall_strobe(w_strobe)
  );

`ifdef PS2_PARITY_CHECK_EN
  logic r_parity;
  // Odd parity: data bits plus parity bit must contain an odd number of ones.
  assign w_parity_bad = ~(^{r_shift, r_parity});
`else
  assign w_parity_bad = 1'b0;
`endif

  // A strobe in the same cycle restarts the count, so it wins over a timeout.
  assign w_timeout_hit = (r_state != ST_IDLE) && !w_strobe &&
                         (r_timeout == TW'(TIMEOUT_CYCLES - 1));

  assign w_hid = ps2_to_hid(r_byte, r_ext);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= 3'd0;
      r_shift     <= 8'h00;
      r_byte      <= 8'h00;
      r_byte_rdy  <= 1'b0;
      r_timeout   <= '0;
      r_ext       <= 1'b0;
      r_brk       <= 1'b0;
      r_keycode   <= HID_NONE;
      r_key_valid <= 1'b0;
      r_rx_error  <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      r_parity    <= 1'b0;
`endif
    end else begin
      r_key_valid <= 1'b0;
      r_rx_error  <= 1'b0;
      r_byte_rdy  <= 1'b0;

      // Accepted byte, one cycle after its stop bit: prefixes only set flags.
      if (r_byte_rdy) begin
        if (r_byte == PS2_EXT) begin
          r_ext <= 1'b1;
        end else if (r_byte == PS2_BRK) begin
          r_brk <= 1'b1;
        end else begin
          r_ext <= 1'b0;
          r_brk <= 1'b0;
          if (w_hid != HID_NONE) begin
            if (r_brk) begin
              if (w_hid == r_keycode) begin
                r_keycode   <= HID_NONE;
                r_key_valid <= 1'b1;
              end
            end else if (w_hid != r_keycode) begin
              // Typematic repeats of the held key leave keycode and key_valid alone.
              r_keycode   <= w_hid;
              r_key_valid <= 1'b1;
            end
          end
        end
      end

      if ((r_state == ST_IDLE) || w_strobe) begin
        r_timeout <= '0;
      end else begin
        r_timeout <= r_timeout + TW'(1);
      end

      if (w_timeout_hit) begin
        r_state    <= ST_IDLE;
        r_rx_error <= 1'b1;
        r_ext      <= 1'b0;
        r_brk      <= 1'b0;
      end else if (w_strobe) begin
        case (r_state)
          ST_IDLE: begin
            if (!w_data) begin
              r_state   <= ST_DATA;
              r_bit_cnt <= 3'd0;
              r_shift   <= 8'h00;
            end
          end
          ST_DATA: begin
            r_shift   <= {w_data, r_shift[7:1]};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) begin
              r_state <= ST_PARITY;
            end
          end
          ST_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
            r_parity <= w_data;
`endif
            r_state <= ST_STOP;
          end
          ST_STOP: begin
            r_state <= ST_IDLE;
            if (!w_data || w_parity_bad) begin
              r_rx_error <= 1'b1;
              r_ext      <= 1'b0;
              r_brk      <= 1'b0;
            end else begin
              r_byte     <= r_shift;
              r_byte_rdy <= 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.keycode   = r_keycode;
  assign bus.key_valid = r_key_valid;
  assign bus.rx_error  = r_rx_error;

endmodule

// File: tb/tb_ps2_keycode_rx.sv
// tb/tb_ps2_keycode_rx.sv - directed self-checking bench for ps2_keycode_rx
module tb_ps2_keycode_rx;
  import ps2_pkg::*;

  localparam int HALF = 25;

  logic Clk = 1'b0;
  logic Reset = 1'b1;

  ps2_keycode_rx_if bus();

  ps2_keycode_rx #(
    .FILTER_LEN    (8),
    .TIMEOUT_CYCLES(50000)
  ) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  always #10 Clk = ~Clk;

  int checks = 0;
  int errors = 0;

  int   kv_cnt = 0;
  int   err_cnt = 0;
  logic both_seen = 1'b0;
  logic change_no_pulse = 1'b0;
  logic [7:0] prev_kc = 8'h00;

  always @(negedge Clk) begin
    if (!Reset) begin
      if (bus.key_valid) kv_cnt++;
      if (bus.rx_error) err_cnt++;
      if (bus.key_valid && bus.rx_error) both_seen = 1'b1;
      if (bus.keycode !== prev_kc && bus.key_valid !== 1'b1) change_no_pulse = 1'b1;
    end
    prev_kc = bus.keycode;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic ps2_bit(input logic b, input bit glitch);
    bus.ps2_data = b;
    if (glitch) begin
      wait_clks(10);
      bus.ps2_clk = 1'b0;
      wait_clks(5);
      bus.ps2_clk = 1'b1;
      wait_clks(HALF - 15);
    end else begin
      wait_clks(HALF);
    end
    bus.ps2_clk = 1'b0;
    wait_clks(HALF);
    bus.ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                            input int glitch_bit, input int nbits);
    logic [10:0] frame;
    frame = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(frame[i], i == glitch_bit);
    bus.ps2_data = 1'b1;
    wait_clks(40);
  endtask

  task automatic send(input logic [7:0] b);
    send_frame(b, 1'b0, 1'b0, -1, 11);
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    wait_clks(5);
    Reset = 1'b0;
    wait_clks(5);
  endtask

  task automatic test_reset();
    wait_clks(5);
    checks++;
    if (bus.keycode !== 8'h00) begin errors++; $display("FAIL reset_keycode: got %h want 00", bus.keycode); end
    checks++;
    if (bus.key_valid !== 1'b0 || bus.rx_error !== 1'b0) begin
      errors++; $display("FAIL reset_pulses: key_valid=%b rx_error=%b want 0 0", bus.key_valid, bus.rx_error);
    end
    Reset = 1'b0;
    wait_clks(5);
  endtask

  task automatic test_glitch();
    int kv0, e0;
    kv0 = kv_cnt; e0 = err_cnt;
    send_frame(8'h29, 1'b0, 1'b0, 3, 11);
    checks++;
    if (bus.keycode !== 8'h2C) begin errors++; $display("FAIL glitch_keycode: got %h want 2C", bus.keycode); end
    checks++;
    if (kv_cnt - kv0 !== 1 || err_cnt - e0 !== 0) begin
      errors++; $display("FAIL glitch_pulses: key_valid=%0d rx_error=%0d want 1 0", kv_cnt - kv0, err_cnt - e0);
    end
  endtask

  task automatic test_typematic();
    int kv0;
    do_reset();
    kv0 = kv_cnt;
    send(8'h29);
    checks++;
    if (bus.keycode !== 8'h2C || kv_cnt - kv0 !== 1) begin
      errors++; $display("FAIL make_space: keycode=%h pulses=%0d want 2C 1", bus.keycode, kv_cnt - kv0);
    end
    send(8'h29);
    checks++;
    if (bus.keycode !== 8'h2C || kv_cnt - kv0 !== 1) begin
      errors++; $display("FAIL repeat_space: keycode=%h pulses=%0d want 2C 1", bus.keycode, kv_cnt - kv0);
    end
    send(8'hF0);
    send(8'h29);
    checks++;
    if (bus.keycode !== 8'h00 || kv_cnt - kv0 !== 2) begin
      errors++; $display("FAIL break_space: keycode=%h pulses=%0d want 00 2", bus.keycode, kv_cnt - kv0);
    end
  endtask

  task automatic test_extended();
    int kv0;
    send(8'hE0); send(8'h75);
    checks++;
    if (bus.keycode !== 8'h52) begin errors++; $display("FAIL ext_up_make: got %h want 52", bus.keycode); end
    send(8'hE0); send(8'hF0); send(8'h75);
    checks++;
    if (bus.keycode !== 8'h00) begin errors++; $display("FAIL ext_up_break: got %h want 00", bus.keycode); end
    send(8'hE0); send(8'h72);
    checks++;
    if (bus.keycode !== 8'h51) begin errors++; $display("FAIL ext_down_make: got %h want 51", bus.keycode); end
    kv0 = kv_cnt;
    send(8'hF0); send(8'h29);
    send(8'h75);
    checks++;
    if (bus.keycode !== 8'h51 || kv_cnt - kv0 !== 0) begin
      errors++; $display("FAIL other_break_unmapped: keycode=%h pulses=%0d want 51 0", bus.keycode, kv_cnt - kv0);
    end
  endtask

  task automatic test_parity(output logic [7:0] exp_key);
    int e0;
    e0 = err_cnt;
    send_frame(8'h1C, 1'b1, 1'b0, -1, 11);
`ifdef PS2_PARITY_CHECK_EN
    exp_key = 8'h51;
    checks++;
    if (bus.keycode !== exp_key || err_cnt - e0 !== 1) begin
      errors++; $display("FAIL bad_parity: keycode=%h errors=%0d want %h 1", bus.keycode, err_cnt - e0, exp_key);
    end
`else
    exp_key = 8'h04;
    checks++;
    if (bus.keycode !== exp_key || err_cnt - e0 !== 0) begin
      errors++; $display("FAIL bad_parity: keycode=%h errors=%0d want %h 0", bus.keycode, err_cnt - e0, exp_key);
    end
`endif
  endtask

  task automatic test_framing(input logic [7:0] exp_key);
    int e0, kv0;
    e0 = err_cnt; kv0 = kv_cnt;
    send_frame(8'h1D, 1'b0, 1'b1, -1, 11);
    checks++;
    if (bus.keycode !== exp_key || err_cnt - e0 !== 1 || kv_cnt - kv0 !== 0) begin
      errors++; $display("FAIL bad_stop: keycode=%h errors=%0d pulses=%0d want %h 1 0",
                         bus.keycode, err_cnt - e0, kv_cnt - kv0, exp_key);
    end
    send(8'hE0);
    send_frame(8'h1D, 1'b0, 1'b1, -1, 11);
    send(8'h75);
    checks++;
    if (bus.keycode !== exp_key || err_cnt - e0 !== 2) begin
      errors++; $display("FAIL ext_cleared_by_error: keycode=%h errors=%0d want %h 2", bus.keycode, err_cnt - e0, exp_key);
    end
  endtask

  task automatic test_timeout();
    int e0;
    e0 = err_cnt;
    send_frame(8'h23, 1'b0, 1'b0, -1, 5);
    wait_clks(45000);
    checks++;
    if (err_cnt - e0 !== 0) begin errors++; $display("FAIL timeout_early: errors=%0d want 0", err_cnt - e0); end
    wait_clks(5100);
    checks++;
    if (err_cnt - e0 !== 1) begin errors++; $display("FAIL timeout_error: errors=%0d want 1", err_cnt - e0); end
    checks++;
    if (dut.r_state !== ST_IDLE) begin errors++; $display("FAIL timeout_idle: state=%0d want %0d", dut.r_state, ST_IDLE); end
    send(8'h23);
    checks++;
    if (bus.keycode !== 8'h07) begin errors++; $display("FAIL after_timeout: got %h want 07", bus.keycode); end
  endtask

  task automatic test_reset_midframe();
    int e0;
    e0 = err_cnt;
    send_frame(8'h29, 1'b0, 1'b0, -1, 6);
    do_reset();
    wait_clks(100);
    checks++;
    if (bus.keycode !== 8'h00 || err_cnt - e0 !== 0) begin
      errors++; $display("FAIL midframe_reset: keycode=%h errors=%0d want 00 0", bus.keycode, err_cnt - e0);
    end
    send(8'h5A);
    checks++;
    if (bus.keycode !== 8'h28) begin errors++; $display("FAIL after_reset: got %h want 28", bus.keycode); end
  endtask

  task automatic test_exclusive();
    checks++;
    if (both_seen !== 1'b0) begin errors++; $display("FAIL valid_and_error: seen=%b want 0", both_seen); end
    checks++;
    if (change_no_pulse !== 1'b0) begin errors++; $display("FAIL change_without_pulse: seen=%b want 0", change_no_pulse); end
  endtask

  initial begin
    logic [7:0] exp_key;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    test_reset();
    test_glitch();
    test_typematic();
    test_extended();
    test_parity(exp_key);
    test_framing(exp_key);
    test_timeout();
    test_reset_midframe();
    test_exclusive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
